mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single cache/memory port between the instruction-fetch requester (u_fetch path) and the load/store requester.
- Sequences one transaction at a time and returns a busywait handshake to each side, matching the busywait style the core already uses.
- Data has priority; a starvation counter guarantees fetch progress.
- Fetch flush (branch) discards an in-flight fetch response without cancelling the memory transaction.

Parameters:
- MAX_STARVE, 4: consecutive data grants allowed while a fetch request waits; then fetch is forced. Range 1..15.
- CNT_W, 4: starvation counter width; must satisfy 2^CNT_W > MAX_STARVE.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- i_req_i  in  1  fetch request, held until busywait low.
- i_addr_i  in  30  fetch word address [31:2].
- i_flush_i  in  1  branch taken; drop pending/in-flight fetch response.
- i_busywait_o  out  1  high while fetch request not yet completed.
- i_rdata_o  out  32  fetch word, valid when i_req_i & ~i_busywait_o.
- d_req_i  in  1  data request, held until busywait low.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  30  data word address.
- d_wdata_i  in  32  store data.
- d_wstrb_i  in  4  byte enables.
- d_busywait_o  out  1  high while data request not completed.
- d_rdata_o  out  32  load data, valid when d_req_i & ~d_busywait_o.
- mem_req_o  out  1  memory request, held until mem_ready_i.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  30  word address.
- mem_wdata_o  out  32  write data.
- mem_wstrb_o  out  4  byte enables (4'b0000 on reads).
- mem_ready_i  in  1  memory completes the transaction this cycle.
- mem_rdata_i  in  32  read data, valid with mem_ready_i.

Behaviour:
- Reset (async, rst_ni=0):
  - State = IDLE; starve_cnt = 0; discard = 0.
  - mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, mem_wstrb_o = 0.
  - i_rdata_o and d_rdata_o = 0.
  - Reset mid-transaction abandons it immediately; the memory shares the reset.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE arbitration:
  - Only d_req_i: grant D.
  - Only i_req_i with i_flush_i=0: grant I.
  - Both: grant D, unless starve_cnt == MAX_STARVE, then grant I.
  - On a grant: register the requester's address, data, we and strb into the mem_* outputs; set mem_req_o=1; go to BUSY_x.
- BUSY_x:
  - mem_req_o and all mem_* fields are held stable until mem_ready_i=1.
  - On mem_ready_i: mem_rdata_i is registered into x_rdata_o; mem_req_o drops; go to RESP_x.
  - Exception: in BUSY_I with discard=1, go straight to IDLE, i_rdata_o unchanged, and clear discard.
- RESP_x: lasts one cycle, then IDLE. No regrant from RESP, so a completed request is never issued twice.
- Busywait outputs (combinational):
  - i_busywait_o = i_req_i & ~(state==RESP_I).
  - d_busywait_o = d_req_i & ~(state==RESP_D).
  - A requester not requesting sees busywait 0.
- Latency: request seen in IDLE at cycle 0, mem_req_o=1 at cycle 1; with mem_ready_i in cycle 1, busywait is low at cycle 2. Minimum 3 cycles per transaction, 1 idle cycle between transactions.
- Starvation counter:
  - starve_cnt += 1 on each D grant while i_req_i=1, saturating at MAX_STARVE.
  - starve_cnt = 0 on each I grant, or when i_req_i=0 in IDLE.
- Flush:
  - i_flush_i in BUSY_I sets discard.
  - i_flush_i in RESP_I suppresses the completion: i_busywait_o stays high and the state still goes to IDLE.
  - i_flush_i in IDLE blocks an I grant that cycle.
  - A new fetch address arrives the following cycle.
- Simultaneous events:
  - i_flush_i together with mem_ready_i in BUSY_I: the response is discarded.
  - d_req_i rising during BUSY_I waits in IDLE arbitration.
- Stores: d_rdata_o is not updated on a store.

Decomposition:
- Shared package/header riskbes_defs holds:
  - FSM state encodings, 3-bit: IDLE=0, BUSY_I=1, BUSY_D=2, RESP_I=3, RESP_D=4.
  - The MAX_STARVE default.
- One small sub-module, arb_starve_ctr: saturating counter with inc, clr and at_max outputs.
- Everything else stays flat in mem_port_arbiter.

Test Plan:
- Lone fetch: i_req_i=1, i_addr_i=30'h10, mem_ready_i=1 at the first mem_req_o cycle, mem_rdata_i=32'h00000013 -> mem_addr_o=30'h10 at cycle 1; i_busywait_o=0 and i_rdata_o=32'h00000013 at cycle 2.
- Store with a slow memory: d_req_i=1, d_we_i=1, d_wstrb_i=4'b0011, mem_ready_i delayed 3 cycles -> mem_* stable for 3 cycles; d_busywait_o high until the cycle after ready.
- Contention with MAX_STARVE=4: both requesting continuously -> grant order D,D,D,D,I,D,D,D,D,I; no starvation.
- Flush in flight: i_flush_i pulsed during BUSY_I -> transaction completes on the memory side; i_rdata_o unchanged; i_busywait_o never drops for that request; next fetch is granted afterwards.
- Async reset mid-transaction: rst_ni=0 in BUSY_D between clock edges -> mem_req_o=0 immediately; after release, state IDLE and both busywaits follow the reqs.
- Flush with ready: i_flush_i and mem_ready_i in the same BUSY_I cycle -> response discarded; state returns to IDLE next cycle.

Source files
------------

// File: rtl/riskbes_defs.sv
// Shared definitions for the memory port arbiter.
// Holds the arbiter FSM state encodings and the starvation default.
package riskbes_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_RESP_I = 3'd3;
  localparam logic [2:0] ST_RESP_D = 3'd4;

  localparam int MAX_STARVE_DEF = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the memory port arbiter.
// Ports: clk_i, rst_ni, inc, clr (wins over inc), at_max (cnt == MAX).
module arb_starve_ctr
  import riskbes_defs::*;
#(
  parameter int MAX = MAX_STARVE_DEF,
  parameter int W   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [W-1:0] MaxV = W'(MAX);

  logic [W-1:0] cnt_q;

  assign at_max = (cnt_q == MaxV);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (i_*) and load/store (d_*).
// Ports: busywait handshakes per side, mem_* request/ready bus.
module mem_port_arbiter
  import riskbes_defs::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEF,
  parameter int CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_req_i,
  input  logic [29:0] i_addr_i,
  input  logic        i_flush_i,
  output logic        i_busywait_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [29:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  output logic        d_busywait_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  logic [2:0] state_q;
  logic       discard_q;
  logic       in_idle;
  logic       at_max;
  logic       gnt_i;
  logic       gnt_d;
  logic       drop_i;

  assign in_idle = (state_q == ST_IDLE);

  assign gnt_i = in_idle & i_req_i & ~i_flush_i
               & (~d_req_i | at_max);
  assign gnt_d = in_idle & d_req_i & ~gnt_i;

  // a flush coinciding with ready also kills the response
  assign drop_i = discard_q | i_flush_i;

  // a flush in RESP_I hides the completion from fetch
  assign i_busywait_o = i_req_i
    & ~((state_q == ST_RESP_I) & ~i_flush_i);
  assign d_busywait_o = d_req_i
    & ~(state_q == ST_RESP_D);

  arb_starve_ctr #(
    .MAX (MAX_STARVE),
    .W   (CNT_W)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (gnt_d & i_req_i),
    .clr    (gnt_i | (in_idle & ~i_req_i)),
    .at_max (at_max)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      i_rdata_o   <= '0;
      d_rdata_o   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            state_q     <= ST_BUSY_I;
          end else if (gnt_d) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            mem_wstrb_o <= d_we_i ? d_wstrb_i : 4'b0000;
            state_q     <= ST_BUSY_D;
          end
        end
        ST_BUSY_I: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            discard_q <= 1'b0;
            if (drop_i) begin
              state_q <= ST_IDLE;
            end else begin
              i_rdata_o <= mem_rdata_i;
              state_q   <= ST_RESP_I;
            end
          end else if (i_flush_i) begin
            discard_q <= 1'b1;
          end
        end
        ST_BUSY_D: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              d_rdata_o <= mem_rdata_i;
            end
            state_q <= ST_RESP_D;
          end
        end
        ST_RESP_I, ST_RESP_D: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
